mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and shared main memory.
// master: arbiter side; slave: caches plus memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
);
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_address;
    logic [LINE_W-1:0] i_mem_readdata;
    logic              i_mem_busywait;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_address;
    logic [LINE_W-1:0] d_mem_writedata;
    logic [LINE_W-1:0] d_mem_readdata;
    logic              d_mem_busywait;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_writedata;
    logic [LINE_W-1:0] mem_readdata;
    logic              mem_busywait;

    logic [15:0]       i_grant_cnt;
    logic [15:0]       d_grant_cnt;

    modport master (
        input  i_mem_read, i_mem_address,
        output i_mem_readdata, i_mem_busywait,
        input  d_mem_read, d_mem_write,
        input  d_mem_address, d_mem_writedata,
        output d_mem_readdata, d_mem_busywait,
        output mem_read, mem_write,
        output mem_address, mem_writedata,
        input  mem_readdata, mem_busywait,
        output i_grant_cnt, d_grant_cnt
    );

    modport slave (
        output i_mem_read, i_mem_address,
        input  i_mem_readdata, i_mem_busywait,
        output d_mem_read, d_mem_write,
        output d_mem_address, d_mem_writedata,
        input  d_mem_readdata, d_mem_busywait,
        input  mem_read, mem_write,
        input  mem_address, mem_writedata,
        output mem_readdata, mem_busywait,
        input  i_grant_cnt, d_grant_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line transfers onto one main memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties (default: D wins).
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic          CLK,
    input  logic          RESET,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } state_e;

    state_e            state_q;
    logic              last_d_q;
    logic [LINE_W-1:0] i_rd_q;
    logic [LINE_W-1:0] d_rd_q;
    logic [15:0]       i_cnt_q;
    logic [15:0]       d_cnt_q;

    logic              i_req;
    logic              d_req;
    logic              pick_d;
    logic              rel_i;
    logic              rel_d;

    logic              mem_read_d;
    logic              mem_write_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_d;

    assign i_req = bus.i_mem_read;
    assign d_req = bus.d_mem_read | bus.d_mem_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign pick_d = d_req & (~i_req | ~last_d_q);
`else
    assign pick_d = d_req;
`endif

    assign rel_i = (state_q == RELEASE) & ~last_d_q;
    assign rel_d = (state_q == RELEASE) &  last_d_q;

    assign bus.i_mem_busywait = i_req & ~rel_i;
    assign bus.d_mem_busywait = d_req & ~rel_d;

    // Memory bus mux: only the granted requester reaches memory.
    always_comb begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        unique case (1'b1)
            (state_q == SERVE_I): begin
                mem_read_d = 1'b1;
                mem_addr_d = bus.i_mem_address;
            end
            (state_q == SERVE_D): begin
                mem_read_d  = bus.d_mem_read;
                mem_write_d = bus.d_mem_write;
                mem_addr_d  = bus.d_mem_address;
                mem_wdata_d = bus.d_mem_writedata;
            end
            default: ;
        endcase
    end

    assign bus.mem_read      = mem_read_d;
    assign bus.mem_write     = mem_write_d;
    assign bus.mem_address   = mem_addr_d;
    assign bus.mem_writedata = mem_wdata_d;

    assign bus.i_mem_readdata = i_rd_q;
    assign bus.d_mem_readdata = d_rd_q;
    assign bus.i_grant_cnt    = i_cnt_q;
    assign bus.d_grant_cnt    = d_cnt_q;

    // Grant FSM with registered line capture and saturating counters.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            i_rd_q   <= '0;
            d_rd_q   <= '0;
            i_cnt_q  <= '0;
            d_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q  <= SERVE_D;
                        last_d_q <= 1'b1;
                    end else if (i_req) begin
                        state_q  <= SERVE_I;
                        last_d_q <= 1'b0;
                    end
                end
                SERVE_I: begin
                    if (!bus.mem_busywait) begin
                        i_rd_q  <= bus.mem_readdata;
                        state_q <= RELEASE;
                        if (i_cnt_q != 16'hFFFF)
                            i_cnt_q <= i_cnt_q + 16'd1;
                    end
                end
                SERVE_D: begin
                    if (!bus.mem_busywait) begin
                        if (bus.d_mem_read)
                            d_rd_q <= bus.mem_readdata;
                        state_q <= RELEASE;
                        if (d_cnt_q != 16'hFFFF)
                            d_cnt_q <= d_cnt_q + 16'd1;
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple wait-state memory.
// Expected values are hand-derived per scenario.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int LW = 128;

    logic CLK = 1'b0;
    logic RESET;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int          mem_wait = 0;
    int          wcnt = 0;
    logic [LW-1:0] rd_base = '0;
    bit          rd_mix = 1'b0;
    logic [LW-1:0] wr_data_seen = '0;
    logic [AW-1:0] wr_addr_seen = '0;
    int          wr_seen = 0;

    wire strobe = bus.mem_read | bus.mem_write;

    assign bus.mem_busywait = !(strobe && (wcnt >= mem_wait));
    assign bus.mem_readdata = rd_mix ? (rd_base ^ LW'(bus.mem_address))
                                     : rd_base;

    // Memory: completes after mem_wait busy cycles of a held strobe.
    always @(posedge CLK) begin
        if (strobe && !bus.mem_busywait) begin
            wcnt <= 0;
            if (bus.mem_write) begin
                wr_data_seen <= bus.mem_writedata;
                wr_addr_seen <= bus.mem_address;
                wr_seen      <= wr_seen + 1;
            end
        end else if (strobe) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    task automatic test_reset();
        RESET = 1'b0;
        bus.i_mem_read = 1'b1;
        bus.i_mem_address = '0;
        bus.d_mem_read = 1'b0;
        bus.d_mem_write = 1'b0;
        bus.d_mem_address = '0;
        bus.d_mem_writedata = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if (bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_mem_read: got %0b want 0", bus.mem_read);
        end
        checks++;
        if (bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_mem_write: got %0b want 0", bus.mem_write);
        end
        checks++;
        if (bus.i_mem_busywait !== 1'b1) begin
            errors++;
            $display("FAIL rst_i_busy: got %0b want 1", bus.i_mem_busywait);
        end
        checks++;
        if (bus.d_mem_busywait !== 1'b0) begin
            errors++;
            $display("FAIL rst_d_busy: got %0b want 0", bus.d_mem_busywait);
        end
        checks++;
        if (bus.i_grant_cnt !== 16'd0 || bus.d_grant_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_cnt: got %0h/%0h want 0/0",
                     bus.i_grant_cnt, bus.d_grant_cnt);
        end
        checks++;
        if (bus.i_mem_readdata !== '0 || bus.d_mem_readdata !== '0) begin
            errors++;
            $display("FAIL rst_rdata: got %0h/%0h want 0/0",
                     bus.i_mem_readdata, bus.d_mem_readdata);
        end
        bus.i_mem_read = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_idle: mem_read got %0b want 0",
                     bus.mem_read);
        end
    endtask

    task automatic test_lone_i();
        int  rd_cyc = 0;
        bit  addr_bad = 1'b0;
        bit  done = 1'b0;
        logic [LW-1:0] exp_line;
        exp_line = {16{8'hA5}};
        mem_wait = 3;
        rd_mix = 1'b0;
        rd_base = exp_line;
        bus.i_mem_read = 1'b1;
        bus.i_mem_address = 28'h0000010;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge CLK);
            if (bus.mem_read) begin
                rd_cyc++;
                if (bus.mem_address !== 28'h0000010) addr_bad = 1'b1;
            end
            if (!bus.i_mem_busywait) begin
                done = 1'b1;
                bus.i_mem_read = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL lone_i_timeout: got no release want release");
            bus.i_mem_read = 1'b0;
        end
        checks++;
        if (rd_cyc != 4) begin
            errors++;
            $display("FAIL lone_i_rd_cycles: got %0d want 4", rd_cyc);
        end
        checks++;
        if (addr_bad) begin
            errors++;
            $display("FAIL lone_i_addr: got wrong addr want 10");
        end
        checks++;
        if (bus.i_mem_readdata !== exp_line) begin
            errors++;
            $display("FAIL lone_i_rdata: got %0h want %0h",
                     bus.i_mem_readdata, exp_line);
        end
        checks++;
        if (bus.i_grant_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lone_i_cnt: got %0d want 1", bus.i_grant_cnt);
        end
        checks++;
        if (bus.d_mem_readdata !== '0) begin
            errors++;
            $display("FAIL lone_i_d_rdata: got %0h want 0",
                     bus.d_mem_readdata);
        end
        @(negedge CLK);
        checks++;
        if (bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL lone_i_regrant: mem_read got %0b want 0",
                     bus.mem_read);
        end
    endtask

    task automatic test_writeback();
        int  wr_cyc = 0;
        int  rd_cyc = 0;
        int  wr_base;
        bit  done = 1'b0;
        wr_base = wr_seen;
        mem_wait = 1;
        rd_base = {4{32'hDEADBEEF}};
        bus.d_mem_write = 1'b1;
        bus.d_mem_address = 28'h0000020;
        bus.d_mem_writedata = 128'h1234;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge CLK);
            if (bus.mem_write) wr_cyc++;
            if (bus.mem_read) rd_cyc++;
            if (!bus.d_mem_busywait) begin
                done = 1'b1;
                bus.d_mem_write = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wb_timeout: got no release want release");
            bus.d_mem_write = 1'b0;
        end
        checks++;
        if (wr_cyc != 2 || rd_cyc != 0) begin
            errors++;
            $display("FAIL wb_strobes: got wr=%0d rd=%0d want wr=2 rd=0",
                     wr_cyc, rd_cyc);
        end
        checks++;
        if (wr_seen != wr_base + 1 || wr_addr_seen !== 28'h0000020) begin
            errors++;
            $display("FAIL wb_addr: got n=%0d a=%0h want n=%0d a=20",
                     wr_seen - wr_base, wr_addr_seen, 1);
        end
        checks++;
        if (wr_data_seen !== 128'h1234) begin
            errors++;
            $display("FAIL wb_wdata: got %0h want 1234", wr_data_seen);
        end
        checks++;
        if (bus.d_mem_readdata !== '0) begin
            errors++;
            $display("FAIL wb_d_rdata: got %0h want 0", bus.d_mem_readdata);
        end
        checks++;
        if (bus.d_grant_cnt !== 16'd1 || bus.i_grant_cnt !== 16'd1) begin
            errors++;
            $display("FAIL wb_cnt: got i=%0d d=%0d want i=1 d=1",
                     bus.i_grant_cnt, bus.d_grant_cnt);
        end
        @(negedge CLK);
    endtask

    task automatic test_tie();
        int  i_at = -1;
        int  d_at = -1;
        int  i_bad = 0;
        logic [LW-1:0] exp_i;
        logic [LW-1:0] exp_d;
        mem_wait = 2;
        rd_mix = 1'b1;
        rd_base = {4{32'h0F1E2D3C}};
        exp_i = rd_base ^ 128'h100;
        exp_d = rd_base ^ 128'h200;
        bus.i_mem_read = 1'b1;
        bus.i_mem_address = 28'h0000100;
        bus.d_mem_read = 1'b1;
        bus.d_mem_address = 28'h0000200;
        for (int k = 0; k < 100 && (i_at < 0 || d_at < 0); k++) begin
            @(negedge CLK);
            if (bus.mem_read && bus.mem_address == 28'h0000200
                && !bus.i_mem_busywait)
                i_bad++;
            if (bus.i_mem_read && !bus.i_mem_busywait) begin
                i_at = k;
                bus.i_mem_read = 1'b0;
            end
            if (bus.d_mem_read && !bus.d_mem_busywait) begin
                d_at = k;
                bus.d_mem_read = 1'b0;
            end
        end
        bus.i_mem_read = 1'b0;
        bus.d_mem_read = 1'b0;
        checks++;
        if (i_at < 0 || d_at < 0) begin
            errors++;
            $display("FAIL tie_timeout: got i=%0d d=%0d want both done",
                     i_at, d_at);
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        checks++;
        if (!(i_at < d_at)) begin
            errors++;
            $display("FAIL tie_order: got i@%0d d@%0d want i first",
                     i_at, d_at);
        end
`else
        checks++;
        if (!(d_at < i_at)) begin
            errors++;
            $display("FAIL tie_order: got i@%0d d@%0d want d first",
                     i_at, d_at);
        end
`endif
        checks++;
        if (i_bad != 0) begin
            errors++;
            $display("FAIL tie_i_busy: got %0d low cycles want 0", i_bad);
        end
        checks++;
        if (bus.i_mem_readdata !== exp_i) begin
            errors++;
            $display("FAIL tie_i_rdata: got %0h want %0h",
                     bus.i_mem_readdata, exp_i);
        end
        checks++;
        if (bus.d_mem_readdata !== exp_d) begin
            errors++;
            $display("FAIL tie_d_rdata: got %0h want %0h",
                     bus.d_mem_readdata, exp_d);
        end
        checks++;
        if (bus.i_grant_cnt !== 16'd2 || bus.d_grant_cnt !== 16'd2) begin
            errors++;
            $display("FAIL tie_cnt: got i=%0d d=%0d want i=2 d=2",
                     bus.i_grant_cnt, bus.d_grant_cnt);
        end
        rd_mix = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        bit done = 1'b0;
        logic [LW-1:0] exp_line;
        exp_line = {16{8'h3C}};
        mem_wait = 5;
        rd_base = exp_line;
        bus.d_mem_read = 1'b1;
        bus.d_mem_address = 28'h0000300;
        @(negedge CLK);
        checks++;
        if (bus.mem_read !== 1'b1) begin
            errors++;
            $display("FAIL mid_serve: mem_read got %0b want 1", bus.mem_read);
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL mid_strobes: got r=%0b w=%0b want 0/0",
                     bus.mem_read, bus.mem_write);
        end
        checks++;
        if (bus.d_grant_cnt !== 16'd0 || bus.d_mem_readdata !== '0) begin
            errors++;
            $display("FAIL mid_state: got cnt=%0d rd=%0h want 0/0",
                     bus.d_grant_cnt, bus.d_mem_readdata);
        end
        checks++;
        if (bus.d_mem_busywait !== 1'b1) begin
            errors++;
            $display("FAIL mid_d_busy: got %0b want 1", bus.d_mem_busywait);
        end
        @(negedge CLK);
        RESET = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge CLK);
            if (!bus.d_mem_busywait) begin
                done = 1'b1;
                bus.d_mem_read = 1'b0;
            end
        end
        bus.d_mem_read = 1'b0;
        checks++;
        if (!done || bus.d_mem_readdata !== exp_line) begin
            errors++;
            $display("FAIL mid_retry: got done=%0b rd=%0h want 1/%0h",
                     done, bus.d_mem_readdata, exp_line);
        end
        checks++;
        if (bus.d_grant_cnt !== 16'd1 || bus.i_grant_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_cnt: got i=%0d d=%0d want i=0 d=1",
                     bus.i_grant_cnt, bus.d_grant_cnt);
        end
        @(negedge CLK);
    endtask

    task automatic test_saturation();
        logic [15:0] seen [3];
        bit done;
        logic [15:0] exp_cnt [3];
        exp_cnt[0] = 16'hFFFE;
        exp_cnt[1] = 16'hFFFF;
        exp_cnt[2] = 16'hFFFF;
        mem_wait = 0;
        @(negedge CLK);
        force dut.i_cnt_q = 16'hFFFD;
        #1;
        release dut.i_cnt_q;
        for (int n = 0; n < 3; n++) begin
            done = 1'b0;
            bus.i_mem_read = 1'b1;
            bus.i_mem_address = 28'h0000400;
            for (int k = 0; k < 20 && !done; k++) begin
                @(negedge CLK);
                if (!bus.i_mem_busywait) begin
                    done = 1'b1;
                    bus.i_mem_read = 1'b0;
                end
            end
            bus.i_mem_read = 1'b0;
            seen[n] = bus.i_grant_cnt;
            @(negedge CLK);
            checks++;
            if (!done || seen[n] !== exp_cnt[n]) begin
                errors++;
                $display("FAIL sat_cnt%0d: got done=%0b cnt=%0h want %0h",
                         n, done, seen[n], exp_cnt[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lone_i();
        test_writeback();
        test_tie();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
